// File: rtl/fp_normalize_round_pkg.sv
// Shared types and constants for the FP adder normalize/round stage.
// Mantissa layout: carry, hidden, fraction, guard, round, sticky.
package fp_normalize_round_pkg;

  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MNT_W  = FRAC_W + 5;
  localparam int XEXP_W = EXP_W + 2;

  localparam int CARRY_BIT  = MNT_W - 1;
  localparam int HIDDEN_BIT = MNT_W - 2;
  localparam int GUARD_BIT  = 2;

  localparam logic [XEXP_W-1:0] EXP_MAX = XEXP_W'(255);
  localparam logic [XEXP_W-1:0] BIAS    = XEXP_W'(127);

  typedef logic [MNT_W-1:0] Mantissa_ext;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    Mantissa_ext      mnt;
    logic             op;
    logic             flip;
  } Align_in;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } Float;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } norm_state_t;

endpackage

// File: rtl/fp_normalize_round_round.sv
// Round-to-nearest-even and IEEE single pack of a normalized mantissa.
// Status outputs exist only when FP_STATUS_FLAGS_EN is defined.
module fp_round
  import fp_normalize_round_pkg::*;
(
  input  logic [HIDDEN_BIT:0] mnt,
  input  logic [XEXP_W-1:0]   exp,
  input  logic                sign,
  output Float                res
`ifdef FP_STATUS_FLAGS_EN
  ,
  output logic                inexact,
  output logic                overflow
`endif
);

  logic              g;
  logic              r;
  logic              s;
  logic              lsb;
  logic              inc;
  logic              ovf;
  logic [FRAC_W+1:0] sig;
  logic [XEXP_W-1:0] exp_r;

  always_comb begin
    g   = mnt[GUARD_BIT];
    r   = mnt[GUARD_BIT-1];
    s   = mnt[GUARD_BIT-2];
    lsb = mnt[GUARD_BIT+1];
    inc = g & (r | s | lsb);
    sig = {1'b0, mnt[HIDDEN_BIT:GUARD_BIT+1]}
        + {{(FRAC_W+1){1'b0}}, inc};
    exp_r = exp;
    // Carry out of the hidden bit leaves 1.0 at the next exponent
    if (sig[FRAC_W+1]) begin
      sig   = '0;
      exp_r = exp + XEXP_W'(1);
    end
    ovf      = (exp_r >= EXP_MAX);
    res.sign = sign;
    if (ovf) begin
      res.exp  = '1;
      res.frac = '0;
    end else begin
      res.exp  = exp_r[EXP_W-1:0];
      res.frac = sig[FRAC_W-1:0];
    end
  end

`ifdef FP_STATUS_FLAGS_EN
  assign inexact  = g | r | s;
  assign overflow = ovf;
`endif

endmodule

// File: rtl/fp_normalize_round.sv
// Iterative normalizer + rounder at the tail of the FP adder pipeline.
// FP_STATUS_FLAGS_EN adds flags[2:0] = {overflow, underflow, inexact}.
module fp_normalize_round
  import fp_normalize_round_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  Align_in     in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
`ifdef FP_STATUS_FLAGS_EN
  ,
  output logic [2:0]  flags
`endif
);

  norm_state_t       state_q, state_d;
  logic              sign_q, sign_d;
  logic [XEXP_W-1:0] exp_q, exp_d;
  Mantissa_ext       mnt_q, mnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_data_q, out_data_d;
  Float              rnd_res;

  logic is_zero;
  logic do_rshift;
  logic do_lshift;
  logic do_uflow;
  logic is_norm;

`ifdef FP_STATUS_FLAGS_EN
  logic       uf_q, uf_d;
  logic [2:0] flags_q, flags_d;
  logic       rnd_inexact;
  logic       rnd_overflow;
`endif

  fp_round u_round (
    .mnt      (mnt_q[HIDDEN_BIT:0]),
    .exp      (exp_q),
    .sign     (sign_q),
    .res      (rnd_res)
`ifdef FP_STATUS_FLAGS_EN
    ,
    .inexact  (rnd_inexact),
    .overflow (rnd_overflow)
`endif
  );

  // Mutually exclusive normalize actions
  always_comb begin
    is_zero   = (mnt_q == '0);
    do_rshift = mnt_q[CARRY_BIT];
    is_norm   = !mnt_q[CARRY_BIT] && mnt_q[HIDDEN_BIT];
    do_lshift = !is_zero && !mnt_q[CARRY_BIT]
             && !mnt_q[HIDDEN_BIT]
             && (exp_q > XEXP_W'(1));
    do_uflow  = !is_zero && !mnt_q[CARRY_BIT]
             && !mnt_q[HIDDEN_BIT]
             && (exp_q <= XEXP_W'(1));
  end

  always_comb begin
    state_d    = state_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    mnt_d      = mnt_q;
    out_data_d = out_data_q;
`ifdef FP_STATUS_FLAGS_EN
    uf_d       = uf_q;
    flags_d    = flags_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          sign_d  = in_data.sign
                  ^ (in_data.flip & in_data.op);
          exp_d   = {2'b00, in_data.exp};
          mnt_d   = in_data.mnt;
          state_d = NORM;
`ifdef FP_STATUS_FLAGS_EN
          uf_d    = 1'b0;
`endif
        end
      end
      NORM: begin
        unique case (1'b1)
          is_zero: begin
            sign_d  = 1'b0;
            exp_d   = '0;
            state_d = ROUND;
          end
          do_rshift: begin
            mnt_d = {1'b0, mnt_q[CARRY_BIT:2],
                     mnt_q[1] | mnt_q[0]};
            exp_d   = exp_q + XEXP_W'(1);
            state_d = ROUND;
          end
          do_lshift: begin
            mnt_d = {mnt_q[CARRY_BIT-1:0], 1'b0};
            exp_d = exp_q - XEXP_W'(1);
          end
          do_uflow: begin
            mnt_d   = '0;
            exp_d   = '0;
            state_d = ROUND;
`ifdef FP_STATUS_FLAGS_EN
            uf_d    = 1'b1;
`endif
          end
          is_norm: state_d = ROUND;
          default: state_d = ROUND;
        endcase
      end
      ROUND: begin
        out_data_d = rnd_res;
        state_d    = DONE;
`ifdef FP_STATUS_FLAGS_EN
        flags_d = {rnd_overflow, uf_q,
                   rnd_inexact | uf_q};
`endif
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      mnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      mnt_q       <= mnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FP_STATUS_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uf_q    <= 1'b0;
      flags_q <= '0;
    end else begin
      uf_q    <= uf_d;
      flags_q <= flags_d;
    end
  end

  assign flags = flags_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round with a behavioural reference.
// Build with FP_STATUS_FLAGS_EN to also check the status flags.
module tb_fp_normalize_round;
  import fp_normalize_round_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  Align_in     in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
`ifdef FP_STATUS_FLAGS_EN
  logic [2:0]  flags;
`endif

  fp_normalize_round dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP_STATUS_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   stall_req = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: value-level normalize, nearest-even round, pack.
  // lat = clock edges after the accepting edge until out_valid
  // is seen (3+N edges counting the accepting edge itself).
  function automatic exp_t model(logic sg, logic [7:0] e8,
                                 logic [27:0] mi,
                                 logic op, logic fl);
    exp_t   r;
    longint m;
    longint qv;
    longint rem;
    int     e;
    int     n;
    logic   s;
    logic   ov;
    logic [31:0] ew;
    m = longint'(mi);
    e = int'(e8);
    n = 0;
    s = sg ^ (fl & op);
    r.acc = 0;
    if (m == 0) begin
      r.data = 32'h0;
      r.flg  = 3'b000;
      r.lat  = 2;
      return r;
    end
    if (m >= (64'd1 << 27)) begin
      m = (m >> 1) | (m & 1);
      e = e + 1;
    end else begin
      while (m < (64'd1 << 26) && e > 1) begin
        m = m * 2;
        e = e - 1;
        n++;
      end
    end
    r.lat = 2 + n;
    if (m < (64'd1 << 26)) begin
      r.data = {s, 31'h0};
      r.flg  = 3'b011;
      return r;
    end
    qv  = m / 8;
    rem = m % 8;
    if (rem > 4 || (rem == 4 && (qv % 2) == 1)) qv = qv + 1;
    if (qv == (64'd1 << 24)) begin
      qv = qv / 2;
      e  = e + 1;
    end
    ov = (e >= 255);
    ew = 32'(e);
    if (ov) r.data = {s, 8'hFF, 23'h0};
    else    r.data = {s, ew[7:0], qv[22:0]};
    r.flg = {ov, 1'b0, rem != 0};
    return r;
  endfunction

  task automatic send(logic sg, logic [7:0] e8, logic [27:0] m,
                      logic op, logic fl, bit push);
    exp_t x;
    int   tmo;
    @(negedge clk);
    in_valid     = 1'b1;
    in_data.sign = sg;
    in_data.exp  = e8;
    in_data.mnt  = m;
    in_data.op   = op;
    in_data.flip = fl;
    tmo = 0;
    while (!in_ready && tmo < 300) begin
      @(negedge clk);
      tmo++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (push) begin
      x     = model(sg, e8, m, op, fl);
      x.acc = cyc;
      q.push_back(x);
    end
  endtask

  // Monitor: pops on the first cycle of each result and then
  // checks that the word is held while stalled.
  initial begin
    exp_t cur;
    bit   seen;
    int   stall;
    seen  = 0;
    stall = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen  = 1;
          stall = stall_req;
          stall_req = 0;
          if (q.size() == 0) begin
            check("unexpected_out", 1, 0);
            cur.data = out_data;
            cur.flg  = '0;
          end else begin
            cur = q.pop_front();
            check("latency", cyc - cur.acc, cur.lat);
            check("out_data", out_data, cur.data);
`ifdef FP_STATUS_FLAGS_EN
            check("flags", flags, cur.flg);
`endif
          end
        end else begin
          check("hold_data", out_data, cur.data);
          check("in_ready_busy", in_ready, 0);
        end
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else begin
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end else begin
        seen = 0;
        out_ready = $urandom_range(0, 1) == 1;
      end
    end
  end

  initial begin
    logic [27:0] m;
    logic [31:0] rv;
    int          tmo;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    check("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready2", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);

    send(0, 8'd127, 28'h8000000, 0, 0, 1);
    send(0, 8'd127, 28'h2000000, 1, 0, 1);
    send(0, 8'd127, 28'h4000004, 0, 0, 1);
    send(0, 8'd127, 28'h400000C, 0, 0, 1);
    send(0, 8'd127, 28'h0000000, 1, 1, 1);
    send(0, 8'd127, 28'h4000000, 1, 1, 1);
    send(0, 8'd254, 28'h8000000, 0, 0, 1);
    send(0, 8'd1,   28'h1000000, 1, 0, 1);
    send(1, 8'd254, 28'h7FFFFFC, 0, 0, 1);
    send(1, 8'd30,  28'h0000001, 1, 0, 1);

    stall_req = 5;
    send(0, 8'd100, 28'h5555555, 0, 0, 1);
    send(1, 8'd90,  28'h4321000, 0, 1, 1);

    // Reset while normalizing: 18 left shifts still pending
    send(0, 8'd127, 28'h0000100, 0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(negedge clk);
      check("postrst_out_valid", out_valid, 0);
    end
    check("postrst_in_ready", in_ready, 1);

    for (int i = 0; i < 200; i++) begin
      rv = $urandom;
      m  = rv[27:0] >> $urandom_range(0, 27);
      if ($urandom_range(0, 3) == 0)
        send($urandom_range(0, 1), 8'($urandom_range(0, 20)), m,
             $urandom_range(0, 1), $urandom_range(0, 1), 1);
      else
        send($urandom_range(0, 1), 8'($urandom_range(1, 254)), m,
             $urandom_range(0, 1), $urandom_range(0, 1), 1);
      if (i % 50 == 0) stall_req = $urandom_range(1, 6);
    end

    tmo = 0;
    while ((q.size() != 0 || out_valid) && tmo < 500) begin
      @(negedge clk);
      tmo++;
    end
    check("drain", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Consumer end of the operate-stage output (`Align_in`: sign, exp, extended mantissa, op, flip) in the FP adder pipeline.
- Takes the raw add/subtract result, normalizes it iteratively (one bit shift per cycle), rounds to nearest-even, and packs an IEEE-754 single-precision word.
- Uses a valid/ready handshake on both sides so the iterative normalizer can stall the operate stage.

Parameters:
- EXP_W, 8, exponent width.
- FRAC_W, 23, stored fraction width; extended mantissa width = FRAC_W+5 (carry, hidden, fraction, guard, round, sticky).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  block can accept an operand.
- in_data  in  Align_in  sign, exp[7:0], mnt[27:0], op, flip.
  - mnt bit map: [27] carry, [26] hidden, [25:3] frac, [2] guard, [1] round, [0] sticky.
- out_valid  out  1  `out_data` is valid.
- out_ready  in  1  downstream accepts.
- out_data  out  32  packed result: {sign, exp, frac}.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=0 while in reset, 1 after.
  - out_valid=0; out_data=0; internal registers cleared.
  - Reset mid-operation discards the operation in flight; no output is produced.
- State IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_data and go to NORM.
  - Captured sign = in.sign ^ (in.flip & in.op).
- State NORM, one action per cycle:
  - mnt==0: result forced to +0, go to ROUND.
  - mnt[27]=1: shift right 1 with sticky |= shifted-out bit; exp+1; go to ROUND.
  - mnt[26]=0 and exp>1: shift left 1 (zero fill); exp-1; stay in NORM.
  - mnt[26]=0 and exp<=1: underflow; result forced to signed zero; go to ROUND.
  - Otherwise already normalized: go to ROUND.
  - At most 26 left shifts.
- State ROUND:
  - Round to nearest even: increment when G & (R | S | frac_lsb).
  - Increment carrying out of the hidden bit: mantissa becomes 1.0, exp+1.
  - Final exp>=255: output ±infinity (exp=255, frac=0).
  - Packed word is registered into out_data; go to DONE.
- State DONE:
  - out_valid=1; out_data held stable while out_ready=0.
  - On out_ready, out_valid drops next cycle and state returns to IDLE.
  - No new input is accepted until then; in_ready=0 outside IDLE.
- Latency:
  - out_valid asserts 3+N cycles after the accepting edge, N = number of left shifts.
  - A right shift costs no extra cycle.
  - Throughput is one result per 4+N cycles.
- Inputs with exp=255 are out of scope: treated numerically, no NaN handling.

Optional Feature:
- Macro: FP_STATUS_FLAGS_EN.
- Defined: adds output port `flags[2:0]` = {overflow, underflow, inexact}.
  - Flags are registered with out_data and valid only with out_valid.
  - inexact = G|R|S at the round point, or underflow flush of a nonzero value.
  - Reset value 0.
- Undefined: no port, no flag logic; datapath is identical.

Decomposition:
- Shared definitions package holds:
  - typedefs `Align_in`, `Mantissa_ext`, `Float`;
  - constants EXP_MAX=255, BIAS=127, mantissa bit positions (CARRY_BIT, HIDDEN_BIT, GUARD_BIT);
  - state enum `norm_state_t`.
- One natural sub-module: `fp_round`, purely combinational.
  - Inputs: normalized mnt, exp, sign.
  - Outputs: packed word plus inexact/overflow.
  - Instantiated in the ROUND state datapath.

Test Plan:
- 1.0+1.0: sign0 exp127 mnt=0x8000000 op0 flip0 -> out_data=0x40000000, out_valid 3 cycles after accept.
- 1.5-1.0: exp127 mnt=0x2000000 op1 flip0 -> one left shift, out_data=0x3F000000 at 4 cycles.
- Tie-even: exp127 mnt=0x4000004 -> 0x3F800000; exp127 mnt=0x400000C -> 0x3F800002 (inexact=1 with FP_STATUS_FLAGS_EN).
- Zero and sign: mnt=0 -> 0x00000000; sign0 flip1 op1 exp127 mnt=0x4000000 -> 0xBF800000.
- Overflow: exp254 mnt=0x8000000 -> 0x7F800000, overflow=1; exp1 mnt=0x1000000 -> 0x00000000, underflow=1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles: out_data stable, in_ready=0, second in_valid not accepted.
  - Assert rst_n=0 during NORM: out_valid stays 0, returns to IDLE, in_ready=1 after release.
